// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV M-extension multiply/divide unit, one radix-2 step per clock.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake; req_ready is decoded from state only
//   req_op                 funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   src1, src2             operands, sampled at acceptance
//   kill                   synchronous abort back to idle
//   resp_valid/resp_ready  response handshake
//   result                 result, held while resp_valid
//   busy                   unit not idle
//
// Build option: define MULDIV_DIV_EN to include the restoring divider. Without it,
// divide/remainder ops are still accepted and return all-ones after one cycle.

module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic             fixed_q, fixed_d;
    logic [XLEN-1:0]  fixed_res_q, fixed_res_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic             s1_signed, s2_signed, s1_neg, s2_neg;
    logic [XLEN-1:0]  s1_mag, s2_mag;
    logic [PW-1:0]    prod_fin;
    logic [XLEN-1:0]  mul_res;

`ifdef MULDIV_DIV_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic             rem_neg_q, rem_neg_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dvsr_q, dvsr_d;
    logic [XLEN:0]    trial;
    logic [XLEN-1:0]  quo_fin, rem_fin, div_res;
`endif

    // Operand magnitudes and signs for the incoming request
    always_comb begin
        s1_signed = (req_op == 3'b001) || (req_op == 3'b010) ||
                    (req_op == 3'b100) || (req_op == 3'b110);
        s2_signed = (req_op == 3'b001) || (req_op == 3'b100) || (req_op == 3'b110);
        s1_neg    = s1_signed & src1[XLEN-1];
        s2_neg    = s2_signed & src2[XLEN-1];
        s1_mag    = s1_neg ? (~src1 + XLEN'(1)) : src1;
        s2_mag    = s2_neg ? (~src2 + XLEN'(1)) : src2;
    end

    // Final product sign fix-up and half selection (MUL takes the low half)
    always_comb begin
        prod_fin = neg_q ? (~prod_q + PW'(1)) : prod_q;
        mul_res  = (op_q == 3'b000) ? prod_fin[XLEN-1:0] : prod_fin[PW-1:XLEN];
    end

`ifdef MULDIV_DIV_EN
    // Restoring trial subtraction and final quotient/remainder sign fix-up
    always_comb begin
        trial   = {rem_q, quo_q[XLEN-1]} - {1'b0, dvsr_q};
        quo_fin = neg_q ? (~quo_q + XLEN'(1)) : quo_q;
        rem_fin = rem_neg_q ? (~rem_q + XLEN'(1)) : rem_q;
        div_res = op_q[1] ? rem_fin : quo_fin;
    end
`endif

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        neg_d       = neg_q;
        fixed_d     = fixed_q;
        fixed_res_d = fixed_res_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        result_d    = result_q;
`ifdef MULDIV_DIV_EN
        rem_neg_d   = rem_neg_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvsr_d      = dvsr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    neg_d   = s1_neg ^ s2_neg;
                    fixed_d = 1'b0;
                    cnt_d   = CNT_W'(XLEN);
                    if (!req_op[2]) begin
                        state_d  = S_MUL;
                        mcand_d  = PW'(s1_mag);
                        mplier_d = s2_mag;
                        prod_d   = '0;
                    end else begin
`ifdef MULDIV_DIV_EN
                        state_d   = S_DIV;
                        rem_neg_d = s1_neg;
                        quo_d     = s1_mag;
                        dvsr_d    = s2_mag;
                        rem_d     = '0;
                        // Special cases skip the iterations and finish on the next edge
                        if (src2 == '0) begin
                            fixed_d     = 1'b1;
                            cnt_d       = '0;
                            fixed_res_d = req_op[1] ? src1 : '1;
                        end else if (!req_op[0] && (src1 == MIN_NEG) && (src2 == '1)) begin
                            fixed_d     = 1'b1;
                            cnt_d       = '0;
                            fixed_res_d = req_op[1] ? '0 : src1;
                        end
`else
                        // No divider: one pass through MUL with a fixed all-ones result
                        state_d     = S_MUL;
                        fixed_d     = 1'b1;
                        cnt_d       = '0;
                        fixed_res_d = '1;
`endif
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = fixed_q ? fixed_res_q : mul_res;
                end else begin
                    if (mplier_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = fixed_q ? fixed_res_q : div_res;
                end else begin
                    if (!trial[XLEN]) begin
                        rem_d = trial[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over acceptance and completion; the last result is kept
        if (kill) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            fixed_q     <= 1'b0;
            fixed_res_q <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            result_q    <= '0;
`ifdef MULDIV_DIV_EN
            rem_neg_q   <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            fixed_q     <= fixed_d;
            fixed_res_q <= fixed_res_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            result_q    <= result_d;
`ifdef MULDIV_DIV_EN
            rem_neg_q   <= rem_neg_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvsr_q      <= dvsr_d;
`endif
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign result     = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (XLEN=32). Expected results and
// latencies are pushed when a request is accepted and popped when the response arrives.
`timescale 1ns/1ps

module tb_muldiv_unit;
    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_op = 3'b000;
    logic [XLEN-1:0] src1 = '0;
    logic [XLEN-1:0] src2 = '0;
    logic            kill = 1'b0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            busy;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .src1       (src1),
        .src2       (src2),
        .kill       (kill),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    logic [XLEN-1:0] exp_q[$];
    int              lat_q[$];
    int              n_checks = 0;
    int              n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result using native wide arithmetic
    function automatic logic [XLEN-1:0] model_res(input logic [2:0] op, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic [63:0]            p;
        logic signed [XLEN-1:0] sa, sb;
        logic [XLEN-1:0]        r;
        sa = a;
        sb = b;
        r  = '0;
        case (op)
            3'b000: begin p = {32'd0, a} * {32'd0, b};               r = p[31:0];  end
            3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};   r = p[63:32]; end
            3'b010: begin p = {{32{a[31]}}, a} * {32'd0, b};         r = p[63:32]; end
            3'b011: begin p = {32'd0, a} * {32'd0, b};               r = p[63:32]; end
            3'b100: r = (b == 0) ? 32'hFFFFFFFF :
                        ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(sa / sb));
            3'b101: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: r = (b == 0) ? a :
                        ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(sa % sb));
            default: r = (b == 0) ? a : a % b;
        endcase
`ifndef MULDIV_DIV_EN
        if (op[2]) r = 32'hFFFFFFFF;
`endif
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        if (!op[2]) return 33;
`ifdef MULDIV_DIV_EN
        if (b == 0) return 1;
        if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
`else
        return 1;
`endif
    endfunction

    // Wait for req_ready, present one request, push its expectations
    task automatic send(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("req_ready_wait", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_op    = op;
        src1      = a;
        src2      = b;
        exp_q.push_back(model_res(op, a, b));
        lat_q.push_back(model_lat(op, a, b));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (!resp_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Pop expectations, check latency/result, optionally stall, then handshake
    task automatic collect(input string tag, input int hold);
        logic [XLEN-1:0] er;
        int              el;
        int              cyc;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 64'(1), 64'(0));
            return;
        end
        er = exp_q.pop_front();
        el = lat_q.pop_front();
        wait_resp(cyc);
        check_eq({tag, "_lat"}, 64'(cyc), 64'(el));
        check_eq({tag, "_res"}, 64'(result), 64'(er));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_res"}, 64'(result), 64'(er));
            check_eq({tag, "_hold_flags"}, 64'({resp_valid, req_ready}), 64'(2'b10));
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check_eq({tag, "_hs"}, 64'({resp_valid, req_ready, busy}), 64'(3'b010));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XLEN-1:0] dummy_r;
        logic [XLEN-1:0] er;
        logic [XLEN-1:0] held;
        logic [2:0]      kop;
        logic [2:0]      rop;
        logic [XLEN-1:0] ra, rb;
        int              dummy_l;
        int              el;
        int              cyc;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_flags", 64'({resp_valid, busy, req_ready}), 64'(3'b001));
        check_eq("rst_result", 64'(result), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic and special cases
        send(3'b000, 32'd7, 32'hFFFFFFFD);          collect("mul_7x-3", 0);
        send(3'b001, 32'h80000000, 32'h80000000);   collect("mulh_min", 0);
        send(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);   collect("mulhu_max", 0);
        send(3'b010, 32'hFFFFFFFF, 32'd2);          collect("mulhsu", 0);
        send(3'b100, 32'hFFFFFFF9, 32'd2);          collect("div_-7_2", 0);
        send(3'b110, 32'hFFFFFFF9, 32'd2);          collect("rem_-7_2", 0);
        send(3'b101, 32'd100, 32'd7);               collect("divu_100_7", 0);
        send(3'b111, 32'd100, 32'd7);               collect("remu_100_7", 0);
        send(3'b100, 32'd5, 32'd0);                 collect("div_by0", 0);
        send(3'b111, 32'd5, 32'd0);                 collect("remu_by0", 0);
        send(3'b100, 32'h80000000, 32'hFFFFFFFF);   collect("div_ovf", 0);
        send(3'b110, 32'h80000000, 32'hFFFFFFFF);   collect("rem_ovf", 0);

        // Backpressure with a competing request held during the stall
        send(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
        req_valid = 1'b1;
        req_op    = 3'b000;
        src1      = 32'd3;
        src2      = 32'd5;
        collect("bp", 10);
        exp_q.push_back(model_res(3'b000, 32'd3, 32'd5));
        lat_q.push_back(model_lat(3'b000, 32'd3, 32'd5));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("bp_next_accept", 64'(busy), 64'(1));
        collect("bp_next", 0);

        // Kill five cycles into a long operation
`ifdef MULDIV_DIV_EN
        kop = 3'b101;
`else
        kop = 3'b011;
`endif
        held = result;
        send(kop, 32'd100, 32'd7);
        dummy_r = exp_q.pop_back();
        dummy_l = lat_q.pop_back();
        repeat (4) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check_eq("kill_flags", 64'({resp_valid, busy, req_ready}), 64'(3'b001));
        check_eq("kill_result", 64'(result), 64'(held));
        repeat (40) @(posedge clk);
        #1;
        check_eq("kill_no_resp", 64'({resp_valid, busy}), 64'(2'b00));

        // Kill takes priority over acceptance in idle
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'b000;
        src1      = 32'd9;
        src2      = 32'd9;
        kill      = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        kill      = 1'b0;
        check_eq("kill_vs_accept", 64'(busy), 64'(0));

        send(3'b000, 32'd3, 32'd4);                 collect("mul_3x4", 0);

        // Kill while holding a response: result stays, resp_valid drops
        send(3'b000, 32'd6, 32'd7);
        er = exp_q.pop_front();
        el = lat_q.pop_front();
        wait_resp(cyc);
        check_eq("done_kill_lat", 64'(cyc), 64'(el));
        check_eq("done_kill_res", 64'(result), 64'(er));
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check_eq("done_kill_flags", 64'({resp_valid, busy, req_ready}), 64'(3'b001));
        check_eq("done_kill_keep", 64'(result), 64'(32'd42));

        // Asynchronous reset in the middle of a multiply
        send(3'b000, 32'd123, 32'd456);
        dummy_r = exp_q.pop_back();
        dummy_l = lat_q.pop_back();
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_flags", 64'({resp_valid, busy, req_ready}), 64'(3'b001));
        check_eq("arst_result", 64'(result), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        send(3'b101, 32'd9, 32'd3);                 collect("divu_9_3", 0);

        // Mixed random traffic including zero divisors and small divisors
        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 4 == 0) rb = '0;
            else if (i % 3 == 0) rb = 32'($urandom_range(1, 20));
            send(rop, ra, rb);
            collect("rand", 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
